// File: rtl/ncl_pkg.sv
// ncl_pkg -- shared definitions for the NCL instruction transmitter.
//
// Contents:
//   NCL_DATA_W    : default instruction word width (dual-rail bits I7..I0).
//   NCL_RAIL_NULL : level of one rail in the NULL wavefront; a bus bit is
//                   NULL when both of its rails sit at this level.
//   ncl_state_t   : transmitter FSM states. ERR exists only when
//                   NCL_TX_TIMEOUT_EN is defined.
package ncl_pkg;

    localparam int   NCL_DATA_W    = 8;
    localparam logic NCL_RAIL_NULL = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        NULL = 2'd2
`ifdef NCL_TX_TIMEOUT_EN
        ,
        ERR  = 2'd3
`endif
    } ncl_state_t;

endpackage

// File: rtl/ncl_sync.sv
// ncl_sync -- STAGES-deep flop synchronizer for a single asynchronous bit.
//
// Ports:
//   clk : sampling clock
//   rst : synchronous active-high reset; clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output, STAGES rising edges behind d
module ncl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/ncl_instr_tx.sv
// ncl_instr_tx -- converts single-rail instruction words into a four-phase
// NULL Convention Logic dual-rail wavefront sequence (DATA, NULL, DATA, ...).
//
// Optional feature: define NCL_TX_TIMEOUT_EN to add a per-phase handshake
// timeout. Without it, err is tied 0 and the FSM waits indefinitely.
//
// Handshake: a word is transferred on a rising edge where in_valid and
// in_ready are both 1. in_ready is only high in IDLE with the synchronized
// receiver completion (ko_s) requesting DATA, and never during rst. in_valid
// with in_ready low is ignored and in_data is not captured.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : single-rail word offered
//   in_ready  : word accepted this cycle
//   in_data   : single-rail instruction word
//   out_t     : true rails of the dual-rail bus (flop outputs)
//   out_f     : false rails of the dual-rail bus (flop outputs)
//   ko_in     : asynchronous receiver completion, 1 = want DATA, 0 = want NULL
//   busy      : high whenever the FSM is not in IDLE
//   err       : handshake timeout flag, held until rst
//   fsm_state : current FSM state, for observation
module ncl_instr_tx import ncl_pkg::*; #(
    parameter int DATA_W      = NCL_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_t,
    output logic [DATA_W-1:0] out_f,
    input  logic              ko_in,
    output logic              busy,
    output logic              err,
    output ncl_state_t        fsm_state
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("ncl_instr_tx: SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("ncl_instr_tx: TIMEOUT_CYC must be at least 1");
    end

    localparam logic [DATA_W-1:0] RAILS_NULL = {DATA_W{NCL_RAIL_NULL}};

    ncl_state_t        state, state_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic [DATA_W-1:0] t_next, f_next;
    logic              ko_s;
    logic              transfer;

    ncl_sync #(.STAGES(SYNC_STAGES)) u_ko_sync (
        .clk (clk),
        .rst (rst),
        .d   (ko_in),
        .q   (ko_s)
    );

    assign in_ready = (state == IDLE) && ko_s && !rst;
    assign transfer = in_valid && in_ready;

`ifdef NCL_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;

    // cnt_q counts completed cycles in the current state, so the exit edge
    // into ERR is the TIMEOUT_CYC-th edge after entering DATA or NULL.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || (state_next != state)) begin
            cnt_q <= '0;
        end else if ((state == DATA) || (state == NULL)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err = (state == ERR);
`else
    assign err = 1'b0;
`endif

    // Transitions act on the level of ko_s in the current state only, so
    // any earlier toggling of ko_s inside the state has no effect.
    always_comb begin
        state_next = state;
        data_next  = data_q;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = DATA;
                    data_next  = in_data;
                end
            end
            DATA: begin
                if (!ko_s) begin
                    state_next = NULL;
                end
`ifdef NCL_TX_TIMEOUT_EN
                else if (timeout) begin
                    state_next = ERR;
                end
`endif
            end
            NULL: begin
                if (ko_s) begin
                    state_next = IDLE;
                end
`ifdef NCL_TX_TIMEOUT_EN
                else if (timeout) begin
                    state_next = ERR;
                end
`endif
            end
`ifdef NCL_TX_TIMEOUT_EN
            ERR: begin
                state_next = ERR;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Rails are registered from the next state: the bus only shows a word
    // while in DATA, which is only reachable from IDLE, so a NULL wavefront
    // always separates two DATA wavefronts and t/f are never both high.
    assign t_next = (state_next == DATA) ? data_next  : RAILS_NULL;
    assign f_next = (state_next == DATA) ? ~data_next : RAILS_NULL;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            out_t  <= RAILS_NULL;
            out_f  <= RAILS_NULL;
        end else begin
            state  <= state_next;
            data_q <= data_next;
            out_t  <= t_next;
            out_f  <= f_next;
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_ncl_instr_tx.sv
// tb_ncl_instr_tx -- directed bench for ncl_instr_tx.
// Accepted words are queued as expected dual-rail buses {out_f, out_t} and
// popped when a DATA wavefront appears after NULL. Build with
// NCL_TX_TIMEOUT_EN defined to exercise the timeout path.
module tb_ncl_instr_tx;
    import ncl_pkg::*;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int TO = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic [W-1:0]      out_t;
    logic [W-1:0]      out_f;
    logic              ko_in;
    logic              busy;
    logic              err;
    ncl_state_t        fsm_state;

    logic ko_drv = 1'b1;
    logic rx_en  = 1'b0;
    logic rx_ko  = 1'b1;
    logic mon_en = 1'b0;

    assign ko_in = rx_en ? rx_ko : ko_drv;

    ncl_instr_tx #(
        .DATA_W      (W),
        .SYNC_STAGES (SS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_t     (out_t),
        .out_f     (out_f),
        .ko_in     (ko_in),
        .busy      (busy),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // scoreboard
    logic [2*W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // bus monitor: exclusivity every cycle, word order, hold in DATA
    logic           prev_null = 1'b1;
    logic [2*W-1:0] prev_bus  = '0;
    logic           cur_null;
    logic [2*W-1:0] cur_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rail_exclusive", 32'(out_t & out_f), 32'd0);
            cur_null = (out_t == '0) && (out_f == '0);
            if (!cur_null) begin
                chk("data_complete", 32'(out_t ^ out_f), 32'(W'('1)));
            end
            if (!cur_null && prev_null) begin
                chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    cur_exp = exp_q.pop_front();
                    chk("word_value", 32'({out_f, out_t}), 32'(cur_exp));
                end
            end else if (!cur_null && !prev_null) begin
                chk("data_hold", 32'({out_f, out_t}), 32'(prev_bus));
            end
            prev_null = cur_null;
            prev_bus  = {out_f, out_t};
        end
    end

    // modelled receiver: asks for NULL after a complete DATA, DATA after NULL
    always @(negedge clk) begin
        if (rx_en) begin
            if ((out_t | out_f) == '1) begin
                rx_ko = 1'b0;
            end else if ((out_t | out_f) == '0) begin
                rx_ko = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        int k;
        in_valid = 1'b1;
        in_data  = w;
        k = 0;
        while (in_ready !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk("send_ready", 32'(in_ready === 1'b1), 32'd1);
        if (in_ready === 1'b1) begin
            exp_q.push_back({~w, w});
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_null(input string tag, input int limit);
        int k;
        k = 0;
        while (!(out_t == '0 && out_f == '0) && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 32'(out_t == '0 && out_f == '0), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset state (ko_in high, in_ready must still be 0 under rst)
        rst = 1'b1;
        ko_drv = 1'b1;
        tick(3);
        chk("rst_out_t", 32'(out_t), 32'd0);
        chk("rst_out_f", 32'(out_f), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        mon_en = 1'b1;
        rst = 1'b0;
        wait_idle("ready_after_rst", SS + 2);

        // single word C5, then receiver NULL request and return to IDLE
        send(8'hC5);
        chk("c5_out_t", 32'(out_t), 32'hC5);
        chk("c5_out_f", 32'(out_f), 32'h3A);
        chk("c5_busy", 32'(busy), 32'd1);
        chk("c5_in_ready", 32'(in_ready), 32'd0);
        ko_drv = 1'b0;
        wait_null("c5_null_latency", SS + 1);
        ko_drv = 1'b1;
        wait_idle("c5_idle_latency", SS + 1);

        // in_valid pulsed while busy
        send(8'h5A);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h33;
            tick();
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("busy_out_t", 32'(out_t), 32'h5A);
            chk("busy_out_f", 32'(out_f), 32'hA5);
        end
        in_valid = 1'b0;
        ko_drv = 1'b0;
        wait_null("busy_null", 10);
        ko_drv = 1'b1;
        wait_idle("busy_idle", 10);

        // back-to-back 00 then FF with the modelled receiver
        rx_ko = 1'b1;
        rx_en = 1'b1;
        send(8'h00);
        send(8'hFF);
        wait_null("b2b_null", 20);
        wait_idle("b2b_idle", 20);
        rx_en = 1'b0;
        ko_drv = 1'b1;

        // receiver not yet reset: ko_in low from start, word offered
        ko_drv = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ko0_in_ready", 32'(in_ready), 32'd0);
            chk("ko0_out_t", 32'(out_t), 32'd0);
            chk("ko0_out_f", 32'(out_f), 32'd0);
        end
        in_valid = 1'b0;
        ko_drv = 1'b1;
        wait_idle("ko0_release", SS + 2);

        // reset while in DATA
        send(8'hA0);
        chk("a0_out_t", 32'(out_t), 32'hA0);
        rst = 1'b1;
        tick();
        chk("rstdata_out_t", 32'(out_t), 32'd0);
        chk("rstdata_out_f", 32'(out_f), 32'd0);
        chk("rstdata_busy", 32'(busy), 32'd0);
        chk("rstdata_err", 32'(err), 32'd0);
        chk("rstdata_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        wait_idle("rstdata_idle", SS + 2);

        // ko_in stuck at 1 after DATA
        send(8'h81);
`ifdef NCL_TX_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            tick();
            chk($sformatf("timeout_err_c%0d", i), 32'(err), 32'(i == TO));
        end
        chk("err_out_t", 32'(out_t), 32'd0);
        chk("err_out_f", 32'(out_f), 32'd0);
        chk("err_busy", 32'(busy), 32'd1);
        chk("err_in_ready", 32'(in_ready), 32'd0);
        chk("err_state", 32'(fsm_state), 32'(ERR));
        ko_drv = 1'b0;
        tick(5);
        ko_drv = 1'b1;
        tick(5);
        chk("err_held", 32'(err), 32'd1);
        chk("err_held_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_cleared_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_idle("err_idle", SS + 2);
`else
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("noto_err", 32'(err), 32'd0);
            chk("noto_hold", 32'(out_t), 32'h81);
        end
        ko_drv = 1'b0;
        wait_null("noto_null", SS + 1);
        ko_drv = 1'b1;
        wait_idle("noto_idle", SS + 1);
`endif

        tick(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
